ex_out_skid: RTL and testbench
==============================

EX_OUT_SKID -- requirements
Module: ex_out_skid

Interface
REQ-001 SHALL have parameter DW, default 64, width of every data and address path.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port ex_valid  input  1  EX result valid this cycle.
REQ-005 SHALL have port ex_ready  output  1  buffer can accept an EX result.
REQ-006 SHALL have port alu_data_rd  input  DW  register-writeback value from the ALU.
REQ-007 SHALL have port alu_data_mem_csr  input  DW  store/CSR/AMO data from the ALU.
REQ-008 SHALL have port au_addr_pc  input  DW  address-unit result (memory address or branch target).
REQ-009 SHALL have port jmp_ok  input  1  taken branch/jump flag from the ALU.
REQ-010 SHALL have port rd_index  input  5  destination register; rd_wr input 1 writeback enable; mem_op input 1 memory access flag.
REQ-011 SHALL have port flush  input  1  kill all buffered entries (trap/redirect from later stage).
REQ-012 SHALL have ports m_valid output 1, m_ready input 1: downstream valid/ready handshake.
REQ-013 SHALL have outputs m_rd_data DW, m_mem_data DW, m_addr DW, m_rd_index 5, m_rd_wr 1, m_mem_op 1: head-entry payload.
REQ-014 SHALL have outputs redir_valid 1 (one-cycle pulse) and redir_pc DW (redirect target).

Function
REQ-015 SHALL hold two entries: head (drives m_* outputs) and skid; each entry stores all payload fields plus a valid bit.
REQ-016 SHALL drive ex_ready directly from a register equal to NOT skid-valid (no combinational path from m_ready).
REQ-017 SHALL accept an EX result when ex_valid AND ex_ready are both high at a rising edge.
REQ-018 SHALL drive m_valid equal to head-valid; a transfer occurs when m_valid AND m_ready are both high.
REQ-019 SHALL load accepted data into head when head is empty or transferring this cycle and skid is empty; otherwise load it into skid.
REQ-020 SHALL on a head transfer with skid valid move skid into head and clear skid in the same edge.
REQ-021 SHALL keep m_* payload stable while m_valid=1 and m_ready=0.
REQ-022 SHALL preserve acceptance order; no entry is dropped or duplicated except by flush/rst.
REQ-023 SHALL assert redir_valid for exactly one cycle, the cycle after an accepted result with jmp_ok=1, with redir_pc = that result's au_addr_pc.
REQ-024 SHALL still pass an entry with jmp_ok=1 downstream (JAL/JALR link write); redirect does not kill it.
REQ-025 SHALL on flush=1 clear head-valid and skid-valid at that edge, ignore any simultaneous accept, and suppress a redirect generated by that accept.
REQ-026 SHALL treat a redir_valid pulse already in flight when flush rises as still emitted (flush does not retract the current-cycle pulse).
REQ-027 SHALL give flush priority over accept and transfer; rst priority over flush.
REQ-028 SHALL have latency one cycle from accept to m_valid when empty; full throughput (one per cycle) when m_ready held high.
REQ-029 SHALL not change payload registers of an invalid entry in a way observable as m_valid=1.

Reset
REQ-030 SHALL on rst=1 at an edge set head-valid=0, skid-valid=0, ex_ready=1, m_valid=0, redir_valid=0.
REQ-031 SHALL reset m_rd_data, m_mem_data, m_addr, redir_pc to 0, m_rd_index to 0, m_rd_wr and m_mem_op to 0.
REQ-032 SHALL on rst mid-operation discard both entries and any pending redirect; first post-reset accept behaves as from empty.

Verification
REQ-033 Empty, m_ready=1, accept alu_data_rd=0x11, rd_index=5, rd_wr=1 -> next cycle m_valid=1, m_rd_data=0x11, m_rd_index=5; ex_ready stays 1.
REQ-034 m_ready=0, accept A=0x1 then B=0x2 -> head=A, skid=B, ex_ready=0; third ex_valid not accepted; m_ready=1 -> A out, then B out, ex_ready=1.
REQ-035 Accept jmp_ok=1, au_addr_pc=0x8000_0040 -> redir_valid=1 for one cycle, redir_pc=0x8000_0040; entry still appears on m_*.
REQ-036 Head and skid full, flush=1 with ex_valid=1, jmp_ok=1 -> next cycle m_valid=0, ex_ready=1, redir_valid=0.
REQ-037 Continuous ex_valid=1, m_ready=1, 8 results 0..7 -> outputs 0..7 in order, one per cycle, ex_ready never low.
REQ-038 Full buffer, rst=1 one cycle -> m_valid=0, redir_valid=0, all payload outputs 0, ex_ready=1.

Source files
------------

// File: rtl/ex_out_skid.sv
// Two-entry output buffer between EX and the memory stage: a head register that
// drives the downstream payload and a skid register that absorbs one stalled result.
module ex_out_skid #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] alu_data_rd,
    input  logic [DW-1:0] alu_data_mem_csr,
    input  logic [DW-1:0] au_addr_pc,
    input  logic          jmp_ok,
    input  logic [4:0]    rd_index,
    input  logic          rd_wr,
    input  logic          mem_op,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_rd_data,
    output logic [DW-1:0] m_mem_data,
    output logic [DW-1:0] m_addr,
    output logic [4:0]    m_rd_index,
    output logic          m_rd_wr,
    output logic          m_mem_op,
    output logic          redir_valid,
    output logic [DW-1:0] redir_pc
);

    typedef struct packed {
        logic [DW-1:0] rd_data;
        logic [DW-1:0] mem_data;
        logic [DW-1:0] addr;
        logic [4:0]    rd_index;
        logic          rd_wr;
        logic          mem_op;
    } entry_t;

    entry_t        in_e;
    entry_t        head;
    entry_t        skid;
    logic          head_v;
    logic          skid_v;
    logic          rdy;
    logic          redir_v;
    logic [DW-1:0] redir_addr;
    logic          accept;
    logic          xfer;

    assign in_e = '{rd_data:  alu_data_rd,
                    mem_data: alu_data_mem_csr,
                    addr:     au_addr_pc,
                    rd_index: rd_index,
                    rd_wr:    rd_wr,
                    mem_op:   mem_op};

    // ex_ready is registered so there is no timing path from m_ready back to EX;
    // skid only fills when head is stalled, so an accept never finds skid occupied.
    assign accept = ex_valid & rdy;
    assign xfer   = head_v & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            skid       <= '0;
            head_v     <= 1'b0;
            skid_v     <= 1'b0;
            rdy        <= 1'b1;
            redir_v    <= 1'b0;
            redir_addr <= '0;
        end else if (flush) begin
            head_v  <= 1'b0;
            skid_v  <= 1'b0;
            rdy     <= 1'b1;
            redir_v <= 1'b0;
        end else begin
            redir_v <= accept & jmp_ok;
            if (accept && jmp_ok)
                redir_addr <= au_addr_pc;
            if (!head_v || xfer) begin
                if (skid_v) begin
                    head   <= skid;
                    head_v <= 1'b1;
                    skid_v <= 1'b0;
                    rdy    <= 1'b1;
                end else if (accept) begin
                    head   <= in_e;
                    head_v <= 1'b1;
                end else begin
                    head_v <= 1'b0;
                end
            end else if (accept) begin
                skid   <= in_e;
                skid_v <= 1'b1;
                rdy    <= 1'b0;
            end
        end
    end

    assign ex_ready    = rdy;
    assign m_valid     = head_v;
    assign m_rd_data   = head.rd_data;
    assign m_mem_data  = head.mem_data;
    assign m_addr      = head.addr;
    assign m_rd_index  = head.rd_index;
    assign m_rd_wr     = head.rd_wr;
    assign m_mem_op    = head.mem_op;
    assign redir_valid = redir_v;
    assign redir_pc    = redir_addr;

endmodule

// File: tb/tb_ex_out_skid.sv
// Bench for ex_out_skid: directed scenarios with literal expectations, then random
// traffic compared every cycle against a FIFO-of-two reference model.
module tb_ex_out_skid;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst, ex_valid, jmp_ok, rd_wr, mem_op, flush, m_ready;
    logic [DW-1:0] alu_data_rd, alu_data_mem_csr, au_addr_pc;
    logic [4:0]    rd_index;
    logic          ex_ready, m_valid, m_rd_wr, m_mem_op, redir_valid;
    logic [DW-1:0] m_rd_data, m_mem_data, m_addr, redir_pc;
    logic [4:0]    m_rd_index;

    always #5 clk = ~clk;

    ex_out_skid #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_data_rd(alu_data_rd), .alu_data_mem_csr(alu_data_mem_csr),
        .au_addr_pc(au_addr_pc), .jmp_ok(jmp_ok), .rd_index(rd_index),
        .rd_wr(rd_wr), .mem_op(mem_op), .flush(flush), .m_valid(m_valid),
        .m_ready(m_ready), .m_rd_data(m_rd_data), .m_mem_data(m_mem_data),
        .m_addr(m_addr), .m_rd_index(m_rd_index), .m_rd_wr(m_rd_wr),
        .m_mem_op(m_mem_op), .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    typedef struct {
        logic [DW-1:0] rd, mem, addr;
        logic [4:0]    idx;
        logic          wr, mop;
    } ent_t;

    ent_t          mq[$];
    bit            m_redir;
    logic [DW-1:0] m_redir_pc;
    bit            chk_en = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: the buffer is an in-order queue of at most two results.
    always @(posedge clk) begin
        bit   acc, xf;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_redir    = 0;
            m_redir_pc = '0;
        end else if (flush) begin
            mq.delete();
            m_redir = 0;
        end else begin
            acc = ex_valid && (mq.size() < 2);
            xf  = (mq.size() > 0) && m_ready;
            e   = '{rd: alu_data_rd, mem: alu_data_mem_csr, addr: au_addr_pc,
                    idx: rd_index, wr: rd_wr, mop: mem_op};
            if (xf) mq.delete(0);
            if (acc) mq.push_back(e);
            m_redir = acc && jmp_ok;
            if (m_redir) m_redir_pc = au_addr_pc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {63'd0, m_valid}, {63'd0, mq.size() > 0});
            chk("ex_ready", {63'd0, ex_ready}, {63'd0, mq.size() < 2});
            chk("redir_valid", {63'd0, redir_valid}, {63'd0, m_redir});
            if (m_redir) chk("redir_pc", redir_pc, m_redir_pc);
            if (mq.size() > 0 && m_valid) begin
                chk("m_rd_data", m_rd_data, mq[0].rd);
                chk("m_mem_data", m_mem_data, mq[0].mem);
                chk("m_addr", m_addr, mq[0].addr);
                chk("m_rd_index", {59'd0, m_rd_index}, {59'd0, mq[0].idx});
                chk("m_rd_wr", {63'd0, m_rd_wr}, {63'd0, mq[0].wr});
                chk("m_mem_op", {63'd0, m_mem_op}, {63'd0, mq[0].mop});
            end
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit j, input logic [DW-1:0] a);
        ex_valid         = v;
        alu_data_rd      = d;
        alu_data_mem_csr = ~d;
        au_addr_pc       = a;
        jmp_ok           = j;
        rd_index         = d[4:0];
        rd_wr            = 1'b1;
        mem_op           = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        chk({tag, "_ex_ready"}, {63'd0, ex_ready}, 64'd1);
        chk({tag, "_redir_valid"}, {63'd0, redir_valid}, 64'd0);
        chk({tag, "_payload"}, m_rd_data | m_mem_data | m_addr | redir_pc |
            {59'd0, m_rd_index} | {63'd0, m_rd_wr | m_mem_op}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        drive(0, '0, 0, '0);
        rd_wr = 1'b0;
        repeat (2) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        chk_en = 1;

        // Single accept into an empty buffer appears one cycle later.
        m_ready = 1'b1;
        drive(1, 64'h11, 0, 64'h100);
        rd_index = 5'd5;
        step();
        drive(0, '0, 0, '0);
        chk("d033_m_valid", {63'd0, m_valid}, 64'd1);
        chk("d033_m_rd_data", m_rd_data, 64'h11);
        chk("d033_m_rd_index", {59'd0, m_rd_index}, 64'd5);
        chk("d033_ex_ready", {63'd0, ex_ready}, 64'd1);
        repeat (2) step();

        // Stall fills head then skid; third offer is refused; drain in order.
        m_ready = 1'b0;
        drive(1, 64'h1, 0, '0); step();
        drive(1, 64'h2, 0, '0); step();
        chk("d034_head_a", m_rd_data, 64'h1);
        chk("d034_ex_ready_full", {63'd0, ex_ready}, 64'd0);
        drive(1, 64'h3, 0, '0); step();
        drive(0, '0, 0, '0);
        chk("d034_head_hold", m_rd_data, 64'h1);
        m_ready = 1'b1;
        step();
        chk("d034_head_b", m_rd_data, 64'h2);
        chk("d034_ex_ready_back", {63'd0, ex_ready}, 64'd1);
        step();
        chk("d034_empty", {63'd0, m_valid}, 64'd0);

        // Taken jump redirects for one cycle and is still delivered.
        drive(1, 64'h44, 1, 64'h8000_0040); step();
        drive(0, '0, 0, '0);
        chk("d035_redir_valid", {63'd0, redir_valid}, 64'd1);
        chk("d035_redir_pc", redir_pc, 64'h8000_0040);
        chk("d035_m_addr", m_addr, 64'h8000_0040);
        step();
        chk("d035_redir_pulse_end", {63'd0, redir_valid}, 64'd0);
        step();

        // Flush while full kills both entries and the simultaneous jump accept.
        m_ready = 1'b0;
        drive(1, 64'h5, 0, '0); step();
        drive(1, 64'h6, 0, '0); step();
        drive(1, 64'h7, 1, 64'hdead_0000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, '0, 0, '0);
        chk("d036_m_valid", {63'd0, m_valid}, 64'd0);
        chk("d036_ex_ready", {63'd0, ex_ready}, 64'd1);
        chk("d036_redir_valid", {63'd0, redir_valid}, 64'd0);

        // Back-to-back streaming at full rate.
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(i), 0, '0);
            step();
            chk("d037_stream_data", m_rd_data, DW'(i));
            chk("d037_ex_ready", {63'd0, ex_ready}, 64'd1);
        end
        drive(0, '0, 0, '0);
        step();

        // Reset of a full buffer returns everything to zero.
        m_ready = 1'b0;
        drive(1, 64'h9, 1, 64'h123); step();
        drive(1, 64'ha, 0, '0); step();
        drive(0, '0, 0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("d038");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, {$urandom, $urandom});
            rd_wr    = 1'($urandom);
            mem_op   = 1'($urandom);
            m_ready  = $urandom_range(0, 9) < 6;
            flush    = $urandom_range(0, 39) == 0;
            rst      = $urandom_range(0, 149) == 0;
            step();
        end
        rst = 1'b0; flush = 1'b0;
        drive(0, '0, 0, '0);
        step();
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
